// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM stage of the 5-stage pipeline.
package pipe_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bus_state_e;

  localparam int          TIMEOUT_DEF  = 15;
  localparam int          CW_DEF       = 4;
  localparam logic [31:0] BUS_ERR_DATA = 32'h0;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
  } exmem_t;

  function automatic logic word_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Bus sequencer for the MEM stage: request/stall generation with a wait-cycle timeout.
//  state   | meaning
//  IDLE    | no access outstanding; a new access may complete with zero wait
//  BUSY    | request held on the bus, waiting for bus_ready or timeout
module mem_bus_fsm
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic issue,
  input  logic bus_ready,
  output logic bus_req,
  output logic mstall,
  output logic timeout_hit
);

  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  bus_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus_req = issue;
        if (issue && !bus_ready) begin
          state_d = ST_BUSY;
          cnt_d   = CW'(1);
        end
      end
      ST_BUSY: begin
        bus_req     = 1'b1;
        timeout_hit = (cnt_q == TO_VAL);
        // bus_ready takes priority when it coincides with the timeout
        if (bus_ready || timeout_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mstall = bus_req & ~bus_ready & ~timeout_hit;

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: EXE/MEM input register, word load/store over a ready-handshake bus,
// alignment check and qualification of the results passed to MEM/WB.
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        evalid,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  output logic        mstall,
  output logic [31:0] malu,
  output logic [31:0] mmo,
  output logic [4:0]  mrn,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        merr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  exmem_t ex_q, ex_d;
  logic   memop, misal, issue, timeout_hit;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ex_q <= '0;
    else         ex_q <= ex_d;
  end

  always_comb begin
    ex_d = ex_q;
    if (!mstall) begin
      ex_d.valid = evalid;
      ex_d.alu   = ealu;
      ex_d.b     = eb;
      ex_d.rn    = ern;
      ex_d.wreg  = ewreg;
      ex_d.m2reg = em2reg;
      ex_d.wmem  = ewmem;
    end
  end

  assign memop = ex_q.valid & (ex_q.m2reg | ex_q.wmem);
  assign misal = memop & word_misaligned(ex_q.alu);
  assign issue = memop & ~misal;

  mem_bus_fsm #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_bus_fsm (
    .clock      (clock),
    .resetn     (resetn),
    .issue      (issue),
    .bus_ready  (bus_ready),
    .bus_req    (bus_req),
    .mstall     (mstall),
    .timeout_hit(timeout_hit)
  );

  // An aborted or misaligned access must not reach the register file
  assign merr   = misal | (timeout_hit & ~bus_ready);
  assign mwreg  = ex_q.valid & ex_q.wreg & ~merr;
  assign mmo    = (bus_req & ex_q.m2reg & bus_ready) ? bus_rdata : BUS_ERR_DATA;

  assign malu      = ex_q.alu;
  assign mrn       = ex_q.rn;
  assign mm2reg    = ex_q.m2reg;
  assign bus_we    = ex_q.wmem;
  assign bus_addr  = {ex_q.alu[31:2], 2'b00};
  assign bus_wdata = ex_q.b;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Scoreboard bench for pipe_mem_stage: random instruction stream, behavioural slave, reference model.
module tb_pipe_mem_stage;

  localparam int TMO = 15;

  typedef struct {
    bit          v;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
    bit          wreg;
    bit          m2reg;
    bit          wmem;
    int          lat;
    logic [31:0] rdata;
  } instr_t;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rn;
    bit          m2reg;
    bit          mwreg;
    bit          merr;
    logic [31:0] mmo;
    int          stalls;
    bit          access;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        evalid = 1'b0;
  logic [31:0] ealu = '0;
  logic [31:0] eb = '0;
  logic [4:0]  ern = '0;
  logic        ewreg = 1'b0;
  logic        em2reg = 1'b0;
  logic        ewmem = 1'b0;
  logic        mstall, mwreg, mm2reg, merr, bus_req, bus_we;
  logic [31:0] malu, mmo, bus_addr, bus_wdata;
  logic [4:0]  mrn;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;

  int     total = 0;
  int     bad = 0;
  bit     mon_en = 1'b0;
  int     stall_cnt = 0;
  exp_t   exp_q[$];
  instr_t lat_q[$];

  bit          s_active = 1'b0;
  int          s_wl = 0;
  logic [31:0] s_data = '0;

  always #5 clock = ~clock;

  pipe_mem_stage #(.TIMEOUT(TMO), .CW(4)) dut (
    .clock(clock), .resetn(resetn),
    .evalid(evalid), .ealu(ealu), .eb(eb), .ern(ern),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .mstall(mstall), .malu(malu), .mmo(mmo), .mrn(mrn),
    .mwreg(mwreg), .mm2reg(mm2reg), .merr(merr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic exp_t model(input instr_t it);
    exp_t e;
    bit memop, misal;
    memop    = it.v && (it.m2reg || it.wmem);
    misal    = memop && ((it.alu % 4) != 0);
    e.access = memop && !misal;
    e.merr   = misal || (e.access && it.lat > TMO);
    e.stalls = !e.access ? 0 : ((it.lat > TMO) ? TMO : it.lat);
    e.mwreg  = it.v && it.wreg && !e.merr;
    e.mmo    = (e.access && it.m2reg && it.lat <= TMO) ? it.rdata : 32'h0;
    e.alu    = it.alu;
    e.rn     = it.rn;
    e.m2reg  = it.m2reg;
    e.we     = it.wmem;
    e.addr   = it.alu & ~32'h3;
    e.wdata  = it.b;
    return e;
  endfunction

  function automatic instr_t mk(input bit v, input logic [31:0] alu, input logic [31:0] b,
                                input logic [4:0] rn, input bit wreg, input bit m2reg,
                                input bit wmem, input int lat, input logic [31:0] rdata);
    instr_t it;
    it.v = v; it.alu = alu; it.b = b; it.rn = rn; it.wreg = wreg;
    it.m2reg = m2reg; it.wmem = wmem; it.lat = lat; it.rdata = rdata;
    return it;
  endfunction

  function automatic instr_t rand_instr();
    instr_t it;
    int k, r;
    k        = $urandom_range(0, 9);
    it.v     = (k >= 2);
    it.alu   = $urandom;
    it.b     = $urandom;
    it.rn    = 5'($urandom);
    it.wreg  = 1'($urandom_range(0, 1));
    it.m2reg = 1'b0;
    it.wmem  = 1'b0;
    it.rdata = $urandom;
    if (k < 2) begin
      it.m2reg = 1'($urandom_range(0, 1));
      it.wmem  = 1'($urandom_range(0, 1));
    end else if (k >= 5 && k <= 7) begin
      it.m2reg = 1'b1;
      it.wreg  = 1'b1;
    end else if (k >= 8) begin
      it.wmem = 1'b1;
      it.wreg = 1'b0;
    end
    if (k >= 5 && $urandom_range(0, 7) != 0) it.alu[1:0] = 2'b00;
    r = $urandom_range(0, 19);
    if (r < 12)      it.lat = r % 4;
    else if (r < 15) it.lat = $urandom_range(4, 14);
    else if (r == 15) it.lat = TMO;
    else if (r == 16) it.lat = TMO + 1;
    else              it.lat = 99;
    return it;
  endfunction

  task automatic drive(input instr_t it);
    evalid = it.v; ealu = it.alu; eb = it.b; ern = it.rn;
    ewreg = it.wreg; em2reg = it.m2reg; ewmem = it.wmem;
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Present one instruction to the stage and wait until it is taken into MEM
  task automatic issue(input instr_t it);
    int  w;
    bit  st;
    exp_t e;
    w  = 0;
    st = 1'b1;
    drive(it);
    while (st) begin
      @(negedge clock);
      st = mstall;
      @(posedge clock);
      if (st) begin
        w++;
        if (w > 40) begin
          total++; bad++;
          $display("FAIL accept_wait: stalled %0d cycles, want at most %0d", w, TMO);
          finish_now();
        end
      end
    end
    e = model(it);
    exp_q.push_back(e);
    if (e.access) lat_q.push_back(it);
    #1;
  endtask

  // Bus slave: latency and read data per transaction come from the generator
  always @(posedge clock) begin
    #1;
    if (!resetn) begin
      s_active  = 1'b0;
      bus_ready = 1'b0;
    end else begin
      if (!s_active && bus_req) begin
        if (lat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL slave_req: got unexpected bus_req, want none");
          s_wl = 0;
          s_data = 32'h0;
        end else begin
          instr_t s;
          s = lat_q.pop_front();
          s_wl = s.lat;
          s_data = s.rdata;
        end
        s_active = 1'b1;
      end
      bus_ready = s_active && (s_wl == 0);
      bus_rdata = bus_ready ? s_data : $urandom;
    end
  end

  always @(negedge clock) begin
    if (s_active) begin
      if (!bus_req || bus_ready || !mstall) s_active = 1'b0;
      else s_wl--;
    end
  end

  // Monitor: a cycle without stall is the completion of the instruction in MEM
  always @(negedge clock) begin
    if (!mon_en) begin
      stall_cnt = 0;
    end else if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty: got output with no expectation queued");
    end else if (mstall) begin
      exp_t c;
      c = exp_q[0];
      stall_cnt++;
      chk("stall_on_access", 32'(c.access), 32'h1);
      chk("stall_req", 32'(bus_req), 32'h1);
      chk("stall_we", 32'(bus_we), 32'(c.we));
      chk("stall_addr", bus_addr, c.addr);
      chk("stall_wdata", bus_wdata, c.wdata);
    end else begin
      exp_t c;
      c = exp_q.pop_front();
      chk("malu", malu, c.alu);
      chk("mrn", 32'(mrn), 32'(c.rn));
      chk("mm2reg", 32'(mm2reg), 32'(c.m2reg));
      chk("mwreg", 32'(mwreg), 32'(c.mwreg));
      chk("merr", 32'(merr), 32'(c.merr));
      chk("mmo", mmo, c.mmo);
      chk("stall_cycles", 32'(stall_cnt), 32'(c.stalls));
      chk("bus_req", 32'(bus_req), 32'(c.access));
      if (c.access) begin
        chk("bus_we", 32'(bus_we), 32'(c.we));
        chk("bus_addr", bus_addr, c.addr);
        chk("bus_wdata", bus_wdata, c.wdata);
      end
      stall_cnt = 0;
    end
  end

  initial begin
    #1_000_000;
    total++; bad++;
    $display("FAIL watchdog: got no end of run, want completion");
    finish_now();
  end

  initial begin
    instr_t zero, bub;
    zero = mk(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 32'h0);
    bub  = mk(0, 32'h200, 32'h1, 5'd7, 1, 1, 1, 0, 32'h0);
    drive(zero);
    repeat (3) @(posedge clock);
    #2 resetn = 1'b1;
    exp_q.push_back(model(zero));
    mon_en = 1'b1;

    issue(mk(1, 32'h100, 32'h0, 5'd8, 1, 1, 0, 0, 32'h12345678));
    issue(mk(1, 32'h20, 32'hCAFEF00D, 5'd0, 0, 0, 1, 3, 32'h0));
    issue(mk(1, 32'h102, 32'h0, 5'd8, 1, 1, 0, 0, 32'h0));
    issue(mk(1, 32'h80, 32'h0, 5'd5, 1, 1, 0, 99, 32'hDEADBEEF));
    issue(mk(1, 32'h84, 32'h0, 5'd6, 1, 1, 0, TMO, 32'h0BADF00D));
    issue(mk(1, 32'h40, 32'h0, 5'd3, 1, 1, 0, 1, 32'h55AA55AA));
    issue(mk(1, 32'h55, 32'h0, 5'd4, 1, 0, 0, 0, 32'h0));
    issue(bub);
    for (int i = 0; i < 300; i++) issue(rand_instr());
    issue(bub);

    // Reset in the second BUSY cycle of a load the slave never answers
    issue(mk(1, 32'h300, 32'h0, 5'd9, 1, 1, 0, 99, 32'h0));
    drive(bub);
    @(posedge clock);
    @(posedge clock);
    #3;
    chk("pre_rst_req", 32'(bus_req), 32'h1);
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_req", 32'(bus_req), 32'h0);
    chk("rst_mstall", 32'(mstall), 32'h0);
    chk("rst_malu", malu, 32'h0);
    chk("rst_mmo", mmo, 32'h0);
    chk("rst_mrn", 32'(mrn), 32'h0);
    chk("rst_mwreg", 32'(mwreg), 32'h0);
    chk("rst_mm2reg", 32'(mm2reg), 32'h0);
    chk("rst_merr", 32'(merr), 32'h0);
    chk("rst_we", 32'(bus_we), 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    exp_q.delete();
    lat_q.delete();
    drive(zero);
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    exp_q.push_back(model(zero));
    mon_en = 1'b1;

    issue(mk(1, 32'h100, 32'h0, 5'd8, 1, 1, 0, 0, 32'h87654321));
    for (int i = 0; i < 20; i++) issue(rand_instr());
    issue(bub);
    @(negedge clock);
    #1;
    finish_now();
  end

endmodule
